// File: rtl/jpeg_bitstream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_bitstream_pkg
// Brief   : Shared commands, FSM encoding and byte constants for the packer.
// Revision: 1.0
// ============================================================================
package jpeg_bitstream_pkg;

    localparam logic [1:0] CMD_CODE   = 2'd0;
    localparam logic [1:0] CMD_FLUSH  = 2'd1;
    localparam logic [1:0] CMD_MARKER = 2'd2;
    localparam logic [1:0] CMD_RSVD   = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_STUFF   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_MARK_FF = 3'd3,
        ST_MARK_LO = 3'd4
    } state_t;

    localparam logic [7:0] BYTE_FF    = 8'hFF;
    localparam logic [7:0] BYTE_STUFF = 8'h00;
    localparam logic       PAD_BIT    = 1'b1;

    // Keeps the top `cnt` bits of `top`, fills the rest with PAD_BIT.
    function automatic logic [7:0] pad_byte(input logic [7:0] top, input logic [6:0] cnt);
        logic [7:0] keep;
        keep = ~(8'hFF >> cnt);
        return (top & keep) | ({8{PAD_BIT}} & ~keep);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_bitstream_packer_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_bit_accumulator
// Brief   : Left-justified bit accumulator with byte shift-out and append.
// Revision: 1.0
// ============================================================================
module jpeg_bit_accumulator
    import jpeg_bitstream_pkg::*;
#(
    parameter int C_ACC_W   = 64,
    parameter int C_MAX_LEN = 32
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 i_shift,
    input  logic                 i_append,
    input  logic [C_MAX_LEN-1:0] i_code,
    input  logic [5:0]           i_len,
    output logic [6:0]           o_bit_cnt,
    output logic [7:0]           o_top_byte,
    output logic [7:0]           o_pad_byte
);

    logic [C_ACC_W-1:0]   r_acc;
    logic [6:0]           r_bit_cnt;

    logic [6:0]           w_cnt_after;
    logic [C_ACC_W-1:0]   w_acc_sh;
    logic [C_MAX_LEN-1:0] w_code_m;
    logic [C_ACC_W-1:0]   w_code_ext;
    logic [6:0]           w_place;
    logic [C_ACC_W-1:0]   w_acc_nx;
    logic [6:0]           w_cnt_nx;

    // A partial shift (flush pad) empties the accumulator entirely.
    assign w_cnt_after = !i_shift           ? r_bit_cnt :
                         (r_bit_cnt >= 7'd8) ? r_bit_cnt - 7'd8 : 7'd0;
    assign w_acc_sh    = i_shift ? (r_acc << 8) : r_acc;
    assign w_code_m    = i_code & ~({C_MAX_LEN{1'b1}} << i_len);
    assign w_code_ext  = {{(C_ACC_W-C_MAX_LEN){1'b0}}, w_code_m};
    assign w_place     = 7'(C_ACC_W) - w_cnt_after - {1'b0, i_len};
    assign w_acc_nx    = i_append ? (w_acc_sh | (w_code_ext << w_place)) : w_acc_sh;
    assign w_cnt_nx    = i_append ? (w_cnt_after + {1'b0, i_len}) : w_cnt_after;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_acc     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_acc     <= w_acc_nx;
            r_bit_cnt <= w_cnt_nx;
        end
    end

    assign o_bit_cnt  = r_bit_cnt;
    assign o_top_byte = r_acc[C_ACC_W-1 -: 8];
    assign o_pad_byte = pad_byte(r_acc[C_ACC_W-1 -: 8], r_bit_cnt);

endmodule
`default_nettype wire

// File: rtl/jpeg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_bitstream_packer
// Brief   : Huffman field packer with 0xFF stuffing, 1-padding and markers.
// Revision: 1.0
// ============================================================================
module jpeg_bitstream_packer
    import jpeg_bitstream_pkg::*;
#(
    parameter int C_ACC_W   = 64,
    parameter int C_MAX_LEN = 32
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_cmd,
    input  logic [C_MAX_LEN-1:0] in_code,
    input  logic [5:0]           in_len,
    output logic [7:0]           fifo_wdata,
    output logic                 fifo_wen,
    input  logic                 fifo_wfull,
    output logic                 busy,
    output logic [31:0]          byte_cnt
);

    state_t      r_state;
    state_t      r_ret;
    logic        r_mark_pend;
    logic [7:0]  r_mark_byte;
    logic [31:0] r_byte_cnt;

    logic [6:0]  w_bit_cnt;
    logic [7:0]  w_top;
    logic [7:0]  w_pad;
    logic        w_emit;
    logic [7:0]  w_wdata;
    logic        w_fire;
    logic        w_shift;
    logic        w_accept;
    logic        w_append;
    state_t      w_run_nx;
    state_t      w_done_st;

    jpeg_bit_accumulator #(
        .C_ACC_W   (C_ACC_W),
        .C_MAX_LEN (C_MAX_LEN)
    ) u_acc (
        .wclk       (wclk),
        .wrst       (wrst),
        .i_shift    (w_shift),
        .i_append   (w_append),
        .i_code     (in_code),
        .i_len      (in_len),
        .o_bit_cnt  (w_bit_cnt),
        .o_top_byte (w_top),
        .o_pad_byte (w_pad)
    );

    always_comb begin
        w_emit  = 1'b0;
        w_wdata = BYTE_STUFF;
        case (r_state)
            ST_RUN:     begin w_emit = (w_bit_cnt >= 7'd8); w_wdata = w_top;       end
            ST_FLUSH:   begin w_emit = (w_bit_cnt != 7'd0); w_wdata = w_pad;       end
            ST_STUFF:   begin w_emit = 1'b1;                w_wdata = BYTE_STUFF;  end
            ST_MARK_FF: begin w_emit = 1'b1;                w_wdata = BYTE_FF;     end
            ST_MARK_LO: begin w_emit = 1'b1;                w_wdata = r_mark_byte; end
            default:    begin w_emit = 1'b0;                w_wdata = BYTE_STUFF;  end
        endcase
    end

    assign w_fire    = w_emit & ~fifo_wfull;
    assign w_shift   = w_fire && ((r_state == ST_RUN) || (r_state == ST_FLUSH));
    assign in_ready  = (r_state == ST_RUN) && (w_bit_cnt <= 7'(C_ACC_W-C_MAX_LEN)) && !wrst;
    assign w_accept  = in_valid & in_ready;
    assign w_append  = w_accept && (in_cmd == CMD_CODE);
    assign w_run_nx  = (w_accept && ((in_cmd == CMD_FLUSH) || (in_cmd == CMD_MARKER)))
                       ? ST_FLUSH : ST_RUN;
    assign w_done_st = r_mark_pend ? ST_MARK_FF : ST_RUN;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state     <= ST_RUN;
            r_ret       <= ST_RUN;
            r_mark_pend <= 1'b0;
            r_mark_byte <= 8'h00;
            r_byte_cnt  <= 32'd0;
        end else begin
            if (w_fire)
                r_byte_cnt <= r_byte_cnt + 32'd1;
            case (r_state)
                ST_RUN: begin
                    if (w_accept && (in_cmd == CMD_MARKER)) begin
                        r_mark_pend <= 1'b1;
                        r_mark_byte <= in_code[7:0];
                    end
                    if (w_fire && (w_wdata == BYTE_FF)) begin
                        r_state <= ST_STUFF;
                        r_ret   <= w_run_nx;
                    end else begin
                        r_state <= w_run_nx;
                    end
                end
                // Returning to an already-empty flush skips straight to the marker.
                ST_STUFF: begin
                    if (w_fire)
                        r_state <= ((r_ret == ST_FLUSH) && (w_bit_cnt == 7'd0)) ? w_done_st : r_ret;
                end
                ST_FLUSH: begin
                    if (w_bit_cnt == 7'd0) begin
                        r_state <= w_done_st;
                    end else if (w_fire) begin
                        if (w_wdata == BYTE_FF) begin
                            r_state <= ST_STUFF;
                            r_ret   <= ST_FLUSH;
                        end else if (w_bit_cnt <= 7'd8) begin
                            r_state <= w_done_st;
                        end
                    end
                end
                ST_MARK_FF: begin
                    if (w_fire)
                        r_state <= ST_MARK_LO;
                end
                ST_MARK_LO: begin
                    if (w_fire) begin
                        r_state     <= ST_RUN;
                        r_mark_pend <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign fifo_wen   = w_fire;
    assign fifo_wdata = w_wdata;
    assign busy       = (r_state != ST_RUN) || (w_bit_cnt != 7'd0);
    assign byte_cnt   = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_jpeg_bitstream_packer
// Brief   : Directed self-checking bench for the JPEG bitstream packer.
// Revision: 1.0
// ============================================================================
module tb_jpeg_bitstream_packer;
    import jpeg_bitstream_pkg::*;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [31:0] in_code;
    logic [5:0]  in_len;
    logic [7:0]  fifo_wdata;
    logic        fifo_wen;
    logic        fifo_wfull;
    logic        busy;
    logic [31:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];

    jpeg_bitstream_packer #(.C_ACC_W(64), .C_MAX_LEN(32)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_code    (in_code),
        .in_len     (in_len),
        .fifo_wdata (fifo_wdata),
        .fifo_wen   (fifo_wen),
        .fifo_wfull (fifo_wfull),
        .busy       (busy),
        .byte_cnt   (byte_cnt)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    // Every byte the FIFO would accept, tagged with its cycle.
    always @(negedge wclk) begin
        if (fifo_wen === 1'b1) begin
            wr_q.push_back(fifo_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        wrst = 1'b1; in_valid = 1'b0; in_cmd = CMD_CODE;
        in_code = '0; in_len = '0; fifo_wfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;
        wr_q.delete(); wr_cyc.delete();
    endtask

    task automatic send(input logic [1:0] cmd, input logic [31:0] code, input logic [5:0] len);
        int n;
        n = 0;
        in_valid = 1'b1; in_cmd = cmd; in_code = code; in_len = len;
        @(negedge wclk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge wclk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge wclk);
        while ((busy !== 1'b0 || fifo_wen !== 1'b0) && n < 100) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1; in_valid = 1'b0; in_cmd = CMD_CODE;
        in_code = '0; in_len = '0; fifo_wfull = 1'b0;
        @(negedge wclk);
        checks++;
        if (fifo_wen !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || byte_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: wen=%b rdy=%b busy=%b bc=%0d required 0 0 0 0",
                     fifo_wen, in_ready, busy, byte_cnt);
        end
        @(posedge wclk);
        #1 wrst = 1'b0;
        @(negedge wclk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic test_basic_pack();
        do_reset();
        send(CMD_CODE, 32'b101, 6'd3);
        send(CMD_CODE, 32'b11111, 6'd5);
        @(negedge wclk);
        checks++;
        if (fifo_wen !== 1'b1 || fifo_wdata !== 8'hBF) begin
            errors++;
            $display("FAIL pack_latency: wen=%b data=%h required 1 bf", fifo_wen, fifo_wdata);
        end
        @(posedge wclk);
        #1;
        wait_idle();
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 8'hBF) begin
            errors++;
            $display("FAIL pack_bytes: count=%0d first=%h required 1 bf", wr_q.size(), wr_q[0]);
        end
        checks++;
        if (byte_cnt !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pack_count: byte_cnt=%0d busy=%b required 1 0", byte_cnt, busy);
        end
    endtask

    task automatic test_stuff();
        do_reset();
        send(CMD_CODE, 32'hFF, 6'd8);
        wait_idle();
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 8'hFF || wr_q[1] !== 8'h00 || wr_cyc[1] != wr_cyc[0] + 1) begin
            errors++;
            $display("FAIL stuff_bytes: count=%0d b0=%h b1=%h required 2 ff 00 consecutive",
                     wr_q.size(), wr_q[0], wr_q[1]);
        end
        checks++;
        if (byte_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stuff_count: byte_cnt=%0d required 2", byte_cnt);
        end
    endtask

    task automatic test_flush_pad();
        do_reset();
        send(CMD_CODE, 32'b0, 6'd1);
        send(CMD_FLUSH, 32'h0, 6'd0);
        wait_idle();
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 8'h7F) begin
            errors++;
            $display("FAIL flush_pad: count=%0d first=%h required 1 7f", wr_q.size(), wr_q[0]);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || byte_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_state: busy=%b rdy=%b bc=%0d required 0 1 1", busy, in_ready, byte_cnt);
        end
    endtask

    task automatic test_marker();
        logic [7:0] exp [4];
        int bad;
        exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'hFF; exp[3] = 8'hD9;
        do_reset();
        send(CMD_CODE, 32'h7F, 6'd7);
        send(CMD_MARKER, 32'hD9, 6'd0);
        wait_idle();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr_q.size() != 4 || wr_q[i] !== exp[i]) bad++;
            if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL marker_bytes: count=%0d %h %h %h %h required ff 00 ff d9 consecutive",
                     wr_q.size(), wr_q[0], wr_q[1], wr_q[2], wr_q[3]);
        end
        checks++;
        if (byte_cnt !== 32'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL marker_count: byte_cnt=%0d busy=%b required 4 0", byte_cnt, busy);
        end
    endtask

    task automatic test_multi_flush();
        logic [7:0] exp [5];
        int bad;
        exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h56; exp[3] = 8'h78; exp[4] = 8'h5F;
        do_reset();
        send(CMD_CODE, 32'h12345678, 6'd32);
        send(CMD_RSVD, 32'hFFFFFFFF, 6'd32);
        send(CMD_CODE, 32'b010, 6'd3);
        send(CMD_FLUSH, 32'h0, 6'd0);
        wait_idle();
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (wr_q.size() != 5 || wr_q[i] !== exp[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL multi_bytes: count=%0d %h %h %h %h %h required 12 34 56 78 5f",
                     wr_q.size(), wr_q[0], wr_q[1], wr_q[2], wr_q[3], wr_q[4]);
        end
        checks++;
        if (byte_cnt !== 32'd5) begin
            errors++;
            $display("FAIL multi_count: byte_cnt=%0d required 5", byte_cnt);
        end
    endtask

    task automatic test_back_to_back_stall();
        int wen_seen;
        int bad;
        do_reset();
        fifo_wfull = 1'b1;
        wen_seen = 0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(CMD_CODE, 32'hA5A5, 6'd16);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge wclk);
                    if (fifo_wen !== 1'b0) wen_seen++;
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready: in_ready=%b busy=%b required 0 1", in_ready, busy);
                end
                @(posedge wclk);
                #1 fifo_wfull = 1'b0;
            end
        join
        checks++;
        if (wen_seen != 0) begin
            errors++;
            $display("FAIL stall_wen: writes during stall=%0d required 0", wen_seen);
        end
        wait_idle();
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (wr_q.size() != 10 || wr_q[i] !== 8'hA5) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_bytes: count=%0d bad=%0d required 10 bytes of a5", wr_q.size(), bad);
        end
        checks++;
        if (byte_cnt !== 32'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: byte_cnt=%0d busy=%b required 10 0", byte_cnt, busy);
        end
    endtask

    task automatic test_reset_in_stuff();
        int wen_seen;
        do_reset();
        send(CMD_CODE, 32'hFF, 6'd8);
        @(negedge wclk);
        checks++;
        if (fifo_wen !== 1'b1 || fifo_wdata !== 8'hFF) begin
            errors++;
            $display("FAIL rst_ff: wen=%b data=%h required 1 ff", fifo_wen, fifo_wdata);
        end
        @(posedge wclk);
        #1 fifo_wfull = 1'b1;
        @(negedge wclk);
        checks++;
        if (fifo_wen !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_stuff_hold: wen=%b busy=%b required 0 1", fifo_wen, busy);
        end
        wrst = 1'b1;
        #1;
        checks++;
        if (fifo_wen !== 1'b0 || in_ready !== 1'b0 || byte_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: wen=%b rdy=%b bc=%0d required 0 0 0", fifo_wen, in_ready, byte_cnt);
        end
        @(posedge wclk);
        #1 fifo_wfull = 1'b0;
        @(posedge wclk);
        #1 wrst = 1'b0;
        wr_q.delete(); wr_cyc.delete();
        wen_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            if (fifo_wen !== 1'b0) wen_seen++;
        end
        checks++;
        if (wen_seen != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL rst_no_stuff: writes=%0d required 0", wen_seen);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || byte_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_after: busy=%b rdy=%b bc=%0d required 0 1 0", busy, in_ready, byte_cnt);
        end
        @(posedge wclk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_stuff();
        test_flush_pad();
        test_marker();
        test_multi_flush();
        test_back_to_back_stall();
        test_reset_in_stuff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
